ewrapper_link_txsched: RTL
==========================

# ewrapper_link_txsched

Transmit link-layer scheduler for the eLink TX path. Arbitrates up to N_REQ emesh transaction sources (e.g. write, read-request, read-response), frames each 104-bit transaction into two 72-bit lane-byte beats, and drives the 72-bit parallel word consumed once per slow clock by the TX serializer. Runs entirely in the slow (core) clock domain.

## Interface

- N_REQ, 3: number of requesters, 2..4.
- CLK_DIV_IN  in  1: slow core clock, same clock that strobes the serializer's parallel input.
- IO_RESET  in  1: one clock; reset is synchronous and active-high.
- REQ_VALID  in  N_REQ: requester i has a transaction on REQ_TRAN[i].
- REQ_TRAN  in  104*N_REQ: transaction i at bits [104*i+103:104*i]. Fields: [103:96] header, [95:64] dstaddr, [63:32] srcaddr, [31:0] data.
- REQ_READY  out  N_REQ: one-hot grant; transaction i is accepted on the rising edge where REQ_VALID[i] & REQ_READY[i].
- TX_WAIT  in  1: far-end backpressure; blocks new grants.
- TX_DATA_OUT  out  72: registered word to the serializer. [71:64] frame lane, [63:0] lanes 7..0, one byte per lane.
- TX_BUSY  out  1: registered; high while state is B0 or B1.

## Operation

- States: IDLE (idle word on output), B0 (beat 0 on output), B1 (beat 1 on output).
- Grant window: state IDLE or B1, TX_WAIT=0, and at least one REQ_VALID set. Outside the window, REQ_READY=0.
- REQ_READY is combinational from state, TX_WAIT, REQ_VALID and the round-robin pointer. At most one bit is set, and only for a valid requester.
- On the grant edge:
  - TX_DATA_OUT <= {8'hFF, tran[103:40]}
  - hold register <= tran[39:0]
  - state -> B0
- B0 -> B1, unconditionally: TX_DATA_OUT <= {8'hFF, hold[39:0], 24'h000000}.
- B1 with a grant -> B0 with the next transaction's beat 0. Back-to-back transactions therefore have no idle gap.
- B1 without a grant -> IDLE: TX_DATA_OUT <= 72'h0.
- IDLE without a grant: hold 72'h0.
- Round robin:
  - Pointer p in 0..N_REQ-1. The search starts at p and wraps.
  - After granting requester i, p <= (i+1) mod N_REQ.
  - The pointer is unchanged when there is no grant.
- TX_WAIT:
  - Sampled only in the grant window.
  - An accepted transaction always emits both beats, even if TX_WAIT rises in B0.
  - TX_WAIT high in B1 forces IDLE.
- REQ_TRAN of a requester is sampled only on its grant edge. Changes while unselected are ignored.
- Reset values: TX_DATA_OUT=72'h0, TX_BUSY=0, state=IDLE, p=0, hold=0. REQ_READY=0 during reset.
- Reset mid-transaction drops the remaining beat. The cycle after reset shows 72'h0.

## Timing

- Grant edge k: beat 0 is visible after edge k, beat 1 after edge k+1. Minimum latency from valid to first beat is one edge.
- Peak throughput: one transaction per 2 cycles.
- TX_BUSY goes high after the grant edge. It goes low after the edge leaving B1 without a grant.
- A single requester continuously valid receives a grant every 2 cycles.
- With N requesters all valid, each requester is granted once every 2N cycles.
- No combinational path from REQ_TRAN to TX_DATA_OUT.

## Configuration

- ELINK_TX_FIXED_PRIO_EN defined:
  - Fixed priority; the lowest index wins (requester 0 is highest).
  - The pointer register is not implemented.
  - A continuously valid requester 0 starves all others.
- Not defined: round robin as described in Operation.

## Test plan

- Single txn: req0 valid with tran 104'hA5_11223344_55667788_99AABBCC.
  - Two words: 72'hFF_A511223344556677, then 72'hFF_8899AABBCC000000.
  - Then 72'h0. TX_BUSY high for exactly 2 cycles.
- All three requesters continuously valid: grant order 0,1,2,0,1,2, one grant every 2 cycles. Frame lane stays 8'hFF with no gaps.
- Same stimulus with ELINK_TX_FIXED_PRIO_EN: only req0 is granted.
- TX_WAIT raised during B0 of a txn:
  - Beat 1 is still emitted, then IDLE.
  - No REQ_READY while TX_WAIT=1.
  - A grant occurs on the first edge after TX_WAIT falls.
- IO_RESET asserted during B0: next output 72'h0, TX_BUSY=0, and the pointer restarts at 0. After release, the first grant goes to the lowest valid index.
- REQ_TRAN changed on the cycle after the grant edge: the emitted beats reflect only the value captured at the grant edge.

Source files
------------

// File: rtl/ewrapper_link_txsched_if.sv
// ewrapper_link_txsched_if
// Request/grant bus and serializer-facing outputs of the eLink TX scheduler.
// The master modport is the requester side (transaction sources plus the
// far-end wait). The slave modport is the scheduler itself.
interface ewrapper_link_txsched_if #(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]     REQ_VALID;
    logic [104*N_REQ-1:0] REQ_TRAN;
    logic [N_REQ-1:0]     REQ_READY;
    logic                 TX_WAIT;
    logic [71:0]          TX_DATA_OUT;
    logic                 TX_BUSY;

    modport master (
        output REQ_VALID,
        output REQ_TRAN,
        output TX_WAIT,
        input  REQ_READY,
        input  TX_DATA_OUT,
        input  TX_BUSY
    );

    modport slave (
        input  REQ_VALID,
        input  REQ_TRAN,
        input  TX_WAIT,
        output REQ_READY,
        output TX_DATA_OUT,
        output TX_BUSY
    );
endinterface

// File: rtl/ewrapper_link_txsched.sv
// ewrapper_link_txsched
// eLink TX link-layer scheduler. Arbitrates N_REQ emesh sources and frames
// each 104-bit transaction into two 72-bit words (frame lane + 8 byte lanes)
// for the TX serializer, one word per slow clock.
// Build option: define ELINK_TX_FIXED_PRIO_EN for fixed priority
// (requester 0 highest, no pointer register); default is round robin.
module ewrapper_link_txsched #(
    parameter int N_REQ = 3
) (
    input  logic                          CLK_DIV_IN,
    input  logic                          IO_RESET,
    ewrapper_link_txsched_if.slave        bus
);

    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_B0   = 2'd1,
        ST_B1   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [71:0]      data_q,  data_d;
    logic [39:0]      hold_q,  hold_d;
    logic             busy_q,  busy_d;

    logic             grant_window;
    logic             valid_found;
    logic             gnt_any;
    logic [PTR_W-1:0] gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic [103:0]     sel_tran;

`ifndef ELINK_TX_FIXED_PRIO_EN
    logic [PTR_W-1:0] ptr_q, ptr_d;
    int               rr_cand;
`endif

    // Arbiter: pick one valid requester and raise its grant inside the window.
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant_window = (state_q != ST_B0) && !bus.TX_WAIT && !IO_RESET;
        valid_found  = 1'b0;
        gnt_idx      = '0;
        gnt          = '0;
`ifdef ELINK_TX_FIXED_PRIO_EN
        // Lowest index wins.
        for (int i = 0; i < N_REQ; i++) begin
            if (!valid_found && bus.REQ_VALID[i]) begin
                valid_found = 1'b1;
                gnt_idx     = PTR_W'(i);
            end
        end
`else
        // Search starts at the pointer and wraps.
        rr_cand = 0;
        for (int k = 0; k < N_REQ; k++) begin
            rr_cand = int'(ptr_q) + k;
            if (rr_cand >= N_REQ) begin
                rr_cand = rr_cand - N_REQ;
            end
            if (!valid_found && bus.REQ_VALID[PTR_W'(rr_cand)]) begin
                valid_found = 1'b1;
                gnt_idx     = PTR_W'(rr_cand);
            end
        end
`endif
        gnt_any = grant_window && valid_found;
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Select the granted transaction; only captured on the grant edge.
    always_comb begin
        sel_tran = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == PTR_W'(i)) begin
                sel_tran = bus.REQ_TRAN[104*i +: 104];
            end
        end
    end

    // Framing FSM next-state and next output word.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        hold_d  = hold_q;
`ifndef ELINK_TX_FIXED_PRIO_EN
        ptr_d   = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
`endif
        case (state_q)
            ST_B0: begin
                // Second beat always follows, regardless of TX_WAIT.
                state_d = ST_B1;
                data_d  = {8'hFF, hold_q, 24'h000000};
            end
            ST_IDLE, ST_B1: begin
                if (gnt_any) begin
                    state_d = ST_B0;
                    data_d  = {8'hFF, sel_tran[103:40]};
                    hold_d  = sel_tran[39:0];
                end else begin
                    state_d = ST_IDLE;
                    data_d  = 72'h0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                data_d  = 72'h0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, output word and hold register, synchronous active-high reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge CLK_DIV_IN) begin
        if (IO_RESET) begin
            state_q <= ST_IDLE;
            data_q  <= 72'h0;
            hold_q  <= 40'h0;
            busy_q  <= 1'b0;
`ifndef ELINK_TX_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
`ifndef ELINK_TX_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.REQ_READY   = gnt;
    assign bus.TX_DATA_OUT = data_q;
    assign bus.TX_BUSY     = busy_q;

endmodule
